// File: rtl/rstctrl.sv
// rstctrl: staged multi-domain reset sequencer for the pu32 SoC.
// Define RSTCTRL_WDT_EN to build the watchdog.
module rstctrl #(
  parameter int DOMAINCNT    = 3,
  parameter int RSTCNTRBITSZ = 4,
  parameter int STAGEDELAY   = 2,
  parameter int WDTBITSZ     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 swrst0_i,
  input  logic                 swrst1_i,
  input  logic                 hwrst_i,
  input  logic                 wdten_i,
  input  logic                 wdtkick_i,
  output logic [DOMAINCNT-1:0] rst_o,
  output logic                 pwroff_o,
  output logic                 ready_o,
  output logic [1:0]           cause_o
);

  localparam int IW = (DOMAINCNT > 1) ? $clog2(DOMAINCNT) : 1;
  localparam int SW = (STAGEDELAY > 1) ? $clog2(STAGEDELAY) : 1;
  localparam logic [SW-1:0] STG_LOAD = SW'(STAGEDELAY - 1);
  localparam logic [IW-1:0] LAST = IW'(DOMAINCNT - 1);

  typedef enum logic [1:0] {
    ASSERT,
    RELEASE,
    RUN,
    OFF
  } state_t;

  state_t                  state;
  logic [RSTCNTRBITSZ-1:0] scnt;
  logic [SW-1:0]           stg;
  logic [IW-1:0]           idx;

  logic cold, warm, pwroff, wdt_req, req;
  logic [1:0] cause_nxt;

  assign cold   = swrst0_i & swrst1_i;
  assign warm   = !swrst0_i & swrst1_i;
  assign pwroff = swrst0_i & !swrst1_i;
  assign req    = cold | warm | wdt_req | hwrst_i;

  always_comb begin
    cause_nxt = 2'd1;
    if (cold)         cause_nxt = 2'd0;
    else if (warm)    cause_nxt = 2'd2;
    else if (wdt_req) cause_nxt = 2'd3;
  end

`ifdef RSTCTRL_WDT_EN
  logic [WDTBITSZ-1:0] wcnt;

  assign wdt_req = (state == RUN) && (&wcnt);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wcnt <= '0;
    end else if (state != RUN || !wdten_i || wdtkick_i) begin
      wcnt <= '0;
    end else if (!(&wcnt)) begin
      wcnt <= wcnt + 1'b1;
    end
  end
`else
  logic unused_wdt;

  assign wdt_req    = 1'b0;
  assign unused_wdt = wdten_i ^ wdtkick_i ^ (WDTBITSZ > 0);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ASSERT;
      scnt     <= '1;
      stg      <= '0;
      idx      <= '0;
      rst_o    <= '1;
      ready_o  <= 1'b0;
      pwroff_o <= 1'b0;
      cause_o  <= 2'd0;
    end else if (state != OFF) begin
      if (pwroff) begin
        state    <= OFF;
        pwroff_o <= 1'b1;
        rst_o    <= '1;
        ready_o  <= 1'b0;
      end else if (req) begin
        // held requests pin the stretch at reload
        state   <= ASSERT;
        scnt    <= '1;
        rst_o   <= '1;
        ready_o <= 1'b0;
        cause_o <= cause_nxt;
      end else begin
        case (state)
          ASSERT: begin
            if (scnt != '0) begin
              scnt <= scnt - 1'b1;
            end else begin
              rst_o[0] <= 1'b0;
              stg      <= STG_LOAD;
              idx      <= IW'(1);
              if (DOMAINCNT == 1) begin
                state   <= RUN;
                ready_o <= 1'b1;
              end else begin
                state <= RELEASE;
              end
            end
          end
          RELEASE: begin
            if (stg != '0) begin
              stg <= stg - 1'b1;
            end else begin
              rst_o[idx] <= 1'b0;
              stg        <= STG_LOAD;
              idx        <= idx + 1'b1;
              if (idx == LAST) begin
                state   <= RUN;
                ready_o <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rstctrl.sv
// tb_rstctrl: table-driven scoreboard bench for rstctrl.
// Watchdog vectors change expectation when RSTCTRL_WDT_EN is defined.
module tb_rstctrl;

`ifdef RSTCTRL_WDT_EN
  localparam bit WDT = 1'b1;
`else
  localparam bit WDT = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       swrst0_i, swrst1_i, hwrst_i, wdten_i, wdtkick_i;
  logic [2:0] rst_o;
  logic       pwroff_o, ready_o;
  logic [1:0] cause_o;

  int n_chk = 0;
  int n_pass = 0;

  rstctrl #(
    .DOMAINCNT(3),
    .RSTCNTRBITSZ(4),
    .STAGEDELAY(2),
    .WDTBITSZ(4)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .swrst0_i(swrst0_i),
    .swrst1_i(swrst1_i),
    .hwrst_i(hwrst_i),
    .wdten_i(wdten_i),
    .wdtkick_i(wdtkick_i),
    .rst_o(rst_o),
    .pwroff_o(pwroff_o),
    .ready_o(ready_o),
    .cause_o(cause_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       s0, s1, hw, wen, kick;
    int         n;
    logic [2:0] rst;
    logic       rdy, off;
    logic [1:0] cause;
    string      name;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  task automatic add(input logic s0, s1, hw, wen, kick, input int n,
                     input logic [2:0] r, input logic rdy, off,
                     input logic [1:0] c, input string name);
    vec_t v;
    v.s0 = s0; v.s1 = s1; v.hw = hw; v.wen = wen; v.kick = kick;
    v.n = n; v.rst = r; v.rdy = rdy; v.off = off; v.cause = c;
    v.name = name;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [6:0] exp);
    logic [6:0] got;
    got = {rst_o, ready_o, pwroff_o, cause_o};
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got rst/rdy/off/cause=%b required %b",
                  name, got, exp);
  endtask

  task automatic run_tbl();
    vec_t v, e;
    while (tbl.size() > 0) begin
      v = tbl.pop_front();
      swrst0_i = v.s0; swrst1_i = v.s1; hwrst_i = v.hw;
      wdten_i = v.wen; wdtkick_i = v.kick;
      sb.push_back(v);
      repeat (v.n) @(posedge clk_i);
      @(negedge clk_i);
      e = sb.pop_front();
      chk(e.name, {e.rst, e.rdy, e.off, e.cause});
    end
  endtask

  task automatic idle_in();
    swrst0_i = 0; swrst1_i = 0; hwrst_i = 0; wdten_i = 0; wdtkick_i = 0;
  endtask

  initial begin
    logic [1:0] wc;
    rst_i = 1'b1;
    idle_in();
    #2 chk("reset_state", 7'b111_0_0_00);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    // cold boot, then warm/hwrst/priority/power-off
    add(0,0,0,0,0, 15, 3'b111,0,0,0, "boot_e15");
    add(0,0,0,0,0,  1, 3'b110,0,0,0, "boot_e16");
    add(0,0,0,0,0,  1, 3'b110,0,0,0, "boot_e17");
    add(0,0,0,0,0,  1, 3'b100,0,0,0, "boot_e18");
    add(0,0,0,0,0,  1, 3'b100,0,0,0, "boot_e19");
    add(0,0,0,0,0,  1, 3'b000,1,0,0, "boot_e20");
    add(0,0,0,0,0,  3, 3'b000,1,0,0, "run_hold");
    add(0,1,0,0,0,  1, 3'b111,0,0,2, "warm_1edge");
    add(0,1,0,0,0,  2, 3'b111,0,0,2, "warm_held");
    add(0,0,0,0,0, 15, 3'b111,0,0,2, "warm_str15");
    add(0,0,0,0,0,  1, 3'b110,0,0,2, "warm_str16");
    add(0,0,0,0,0,  2, 3'b100,0,0,2, "warm_d1");
    add(0,0,0,0,0,  2, 3'b000,1,0,2, "warm_ready");
    add(0,1,0,0,0,  1, 3'b111,0,0,2, "warm_pulse");
    add(0,0,0,0,0, 16, 3'b110,0,0,2, "rel_d0");
    add(0,0,0,0,0,  1, 3'b110,0,0,2, "rel_wait");
    add(0,0,1,0,0,  1, 3'b111,0,0,1, "hw_collide");
    add(0,0,0,0,0, 15, 3'b111,0,0,1, "hw_str15");
    add(0,0,0,0,0,  1, 3'b110,0,0,1, "hw_e16");
    add(0,0,0,0,0,  2, 3'b100,0,0,1, "hw_e18");
    add(0,0,0,0,0,  2, 3'b000,1,0,1, "hw_e20");
    add(1,1,1,0,0,  1, 3'b111,0,0,0, "cold_hw_prio");
    add(0,0,0,0,0, 16, 3'b110,0,0,0, "cold_e16");
    add(0,0,0,0,0,  4, 3'b000,1,0,0, "cold_ready");
    add(0,1,1,0,0,  1, 3'b111,0,0,2, "warm_hw_prio");
    add(0,0,0,0,0, 20, 3'b000,1,0,2, "warm_hw_rdy");
    add(1,0,0,0,0,  1, 3'b111,0,1,2, "pwroff");
    add(0,0,1,0,0,  3, 3'b111,0,1,2, "off_hw");
    add(0,1,0,0,0,  3, 3'b111,0,1,2, "off_warm");
    add(1,1,0,0,0,  2, 3'b111,0,1,2, "off_cold");
    add(0,0,0,0,0, 30, 3'b111,0,1,2, "off_idle");
    run_tbl();

    #2 rst_i = 1'b1;
    #1 chk("rst_clears_off", 7'b111_0_0_00);
    @(negedge clk_i);
    rst_i = 1'b0;

    add(0,0,0,0,0, 17, 3'b110,0,0,0, "reboot_e17");
    run_tbl();
    #2 rst_i = 1'b1;
    #1 chk("rst_abort", 7'b111_0_0_00);
    @(negedge clk_i);
    rst_i = 1'b0;

    // watchdog: fires 16 edges into RUN only when built
    wc = WDT ? 2'd3 : 2'd0;
    add(0,0,0,0,0, 20, 3'b000,1,0,0, "boot2_ready");
    add(0,0,0,1,0, 15, 3'b000,1,0,0, "wdt_e15");
    add(0,0,0,1,0,  1, WDT ? 3'b111 : 3'b000, !WDT, 0, wc, "wdt_e16");
    add(0,0,0,1,0, 20, 3'b000,1,0,wc, "wdt_reboot");
    for (int i = 0; i < 4; i++) begin
      add(0,0,0,1,1, 1, 3'b000,1,0,wc, "wdt_kick");
      add(0,0,0,1,0, 9, 3'b000,1,0,wc, "wdt_kicked");
    end
    add(0,0,0,0,0, 30, 3'b000,1,0,wc, "wdt_disabled");
    run_tbl();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rstctrl.md
# rstctrl

Parametrised reset sequencer for the pu32 SoC top level. It generalises the single stretched-reset counter into `DOMAINCNT` reset domains released in a staged order. Domain 0 is the bus, memory and devices; the last domain is the multipu. It decodes software cold reset, warm reset and power-off from the devtbl rst0/rst1 pair, accepts a hardware warm-reset request from multipu, and optionally runs a watchdog.

## Interface
Parameters:
- `DOMAINCNT`, 3: number of reset domains (>=1).
- `RSTCNTRBITSZ`, 4: width of the stretch counter; stretch length is 2^`RSTCNTRBITSZ` cycles.
- `STAGEDELAY`, 2: cycles between releases of consecutive domains (>=1).
- `WDTBITSZ`, 16: watchdog counter width.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `swrst0_i` in 1: devtbl rst0.
- `swrst1_i` in 1: devtbl rst1.
- `hwrst_i` in 1: hardware warm-reset request (multipu `rst_o`), level.
- `wdten_i` in 1: watchdog enable.
- `wdtkick_i` in 1: watchdog restart pulse.
- `rst_o` out `DOMAINCNT`: per-domain reset, active-high.
- `pwroff_o` out 1: power-off latched.
- `ready_o` out 1: all domains released.
- `cause_o` out 2: last reset cause. 0 = external/cold, 1 = hwrst, 2 = sw warm, 3 = watchdog.

## Operation
- Decode:
  - cold = `swrst0_i`&`swrst1_i`
  - warm = !`swrst0_i`&`swrst1_i`
  - pwroff = `swrst0_i`&!`swrst1_i`
  - Request priority: pwroff > cold > warm > watchdog > `hwrst_i`.
- States: ASSERT, RELEASE, RUN, OFF. All outputs are registered.
- ASSERT:
  - All `rst_o` are 1 and `ready_o` is 0.
  - The stretch counter decrements each edge while non-zero.
  - On the edge where the counter is 0: `rst_o[0]` goes to 0, the stage counter loads `STAGEDELAY`-1, and the state moves to RELEASE. If `DOMAINCNT`==1, the state moves to RUN and `ready_o` goes to 1 on that same edge.
- RELEASE:
  - The stage counter decrements each edge.
  - At 0 it releases the next domain index and reloads.
  - On the edge that releases domain `DOMAINCNT`-1, the state moves to RUN and `ready_o` goes to 1.
- RUN: all `rst_o` are 0 and `ready_o` is 1.
- Any request (cold, warm, watchdog, hwrst) in ASSERT, RELEASE or RUN:
  - Next edge: all `rst_o` go to 1, `ready_o` goes to 0, the stretch counter reloads to all ones, the state moves to ASSERT, and `cause_o` is updated (cold→0, hwrst→1, warm→2, watchdog→3).
  - A request held high keeps the counter at reload. Stretching starts on the first edge after the request drops.
- pwroff in any state except OFF: next edge moves to OFF with `pwroff_o`=1, all `rst_o`=1 and `ready_o`=0. OFF ignores every input; only `rst_i` exits it.
- Counters wrap never: the stretch and stage counters saturate at 0.

## Timing
- `rst_i`=1, asynchronously:
  - all `rst_o`=1, `ready_o`=0, `pwroff_o`=0, `cause_o`=0;
  - state ASSERT, stretch counter all ones, watchdog counter 0.
- After `rst_i` (or a request) deasserts, `rst_o[0]` falls at the 2^`RSTCNTRBITSZ`th rising edge (edge 16 at defaults).
- `rst_o[k]` falls k·`STAGEDELAY` edges after `rst_o[0]`. `ready_o` rises with `rst_o[DOMAINCNT-1]`.
- At defaults, `ready_o` rises at edge 20.
- Request to `rst_o` reassertion: 1 edge.
- pwroff to `pwroff_o`: 1 edge.
- When a request and a stage release land on the same edge, the request wins.
- `rst_i` asserted mid-sequence aborts the sequence immediately (asynchronous clear).

## Configuration
- `RSTCTRL_WDT_EN` defined:
  - The `WDTBITSZ`-bit watchdog counter is instantiated. It counts only in RUN with `wdten_i`=1.
  - The counter clears on `wdtkick_i`, on `wdten_i`=0, and outside RUN.
  - On reaching all ones it raises a watchdog request (cause 3) on the next edge.
- `RSTCTRL_WDT_EN` undefined:
  - No counter is built and `wdten_i`/`wdtkick_i` are ignored.
  - `cause_o` never reads 3.

## Test plan
- Defaults, pulse `rst_i`:
  - `rst_o`=3'b111 while asserted.
  - Bits 0, 1 and 2 fall at edges 16, 18 and 20; `ready_o`=1 at edge 20; `cause_o`=0.
- In RUN, drive `swrst1_i`=1 with `swrst0_i`=0 for 3 cycles:
  - `rst_o`=3'b111 after 1 edge and `cause_o`=2.
  - `rst_o[0]` falls 16 edges after the request drops.
- In RELEASE (after `rst_o[0]` falls), assert `hwrst_i` for 1 cycle: all domains reassert, `cause_o`=1, and the full 20-edge sequence reruns.
- Drive `swrst0_i`=1 with `swrst1_i`=0:
  - `pwroff_o`=1 and `rst_o`=3'b111, held through later `hwrst_i` and warm requests.
  - Only `rst_i` clears it.
- Drive `swrst0_i`=`swrst1_i`=1 together with `hwrst_i` (cold + hwrst): `cause_o`=0 (priority).
- With `RSTCTRL_WDT_EN` and `WDTBITSZ`=4, `wdten_i`=1 and no kick:
  - Reset occurs 16 edges after RUN entry with `cause_o`=3.
  - Kicking every 10 cycles produces no reset.
